// File: rtl/mdu_seq.sv
// RV32M multiply/divide sequencer: shift-add multiply / restoring divide, 33 cycles start-to-done.
// Divide-by-zero and signed overflow finish in 1 cycle; stall_E holds IF/ID/E while a start is accepted or RUN.
module mdu_seq #(
    parameter int OP_WIDTH     = 32,
    parameter int FUNCT3_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_E,
    input  logic [FUNCT3_WIDTH-1:0] funct3_E,
    input  logic [OP_WIDTH-1:0]     opA,
    input  logic [OP_WIDTH-1:0]     opB,
    input  logic                    flush_E,
    output logic                    stall_E,
    output logic                    busy,
    output logic                    done,
    output logic [OP_WIDTH-1:0]     mdu_result_E
);

    localparam int W  = OP_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);
    localparam logic [W-1:0]  MIN_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [FUNCT3_WIDTH-1:0] funct3_q, funct3_d;
    logic                    sa_q, sa_d;
    logic                    sb_q, sb_d;
    logic [W-1:0]            a_q, a_d;
    logic [2*W-1:0]          b_q, b_d;
    logic [2*W-1:0]          acc_q, acc_d;
    logic [W-1:0]            res_q, res_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    // Operand decode for the instruction currently in E
    logic         is_div_e, sgn_a_e, sgn_b_e, sa_e, sb_e, special_e, accept_e;
    logic [W-1:0] mag_a_e, mag_b_e, special_res_e;

    always_comb begin
        is_div_e      = funct3_E[2];
        sgn_a_e       = is_div_e ? ~funct3_E[0] : (funct3_E[1:0] != 2'b11);
        sgn_b_e       = is_div_e ? ~funct3_E[0] : ~funct3_E[1];
        sa_e          = sgn_a_e & opA[W-1];
        sb_e          = sgn_b_e & opB[W-1];
        mag_a_e       = sa_e ? -opA : opA;
        mag_b_e       = sb_e ? -opB : opB;
        special_e     = 1'b0;
        special_res_e = '0;
        if (is_div_e && (opB == '0)) begin
            special_e     = 1'b1;
            special_res_e = funct3_E[1] ? opA : '1;
        end else if (is_div_e && !funct3_E[0] && (opA == MIN_NEG) && (opB == '1)) begin
            special_e     = 1'b1;
            special_res_e = funct3_E[1] ? '0 : MIN_NEG;
        end
        accept_e = start_E & ~flush_E;
    end

    // One iteration: divide shifts the dividend MSB into the remainder and the quotient bit into a_q
    logic [W:0]     rem_sh, rem_sub;
    logic           q_bit;
    logic [2*W-1:0] it_acc, it_b;
    logic [W-1:0]   it_a;

    always_comb begin
        rem_sh  = {acc_q[W-1:0], a_q[W-1]};
        rem_sub = rem_sh - {1'b0, b_q[W-1:0]};
        q_bit   = (rem_sh >= {1'b0, b_q[W-1:0]});
        if (funct3_q[2]) begin
            it_acc = {{(W-1){1'b0}}, (q_bit ? rem_sub : rem_sh)};
            it_a   = {a_q[W-2:0], q_bit};
            it_b   = b_q;
        end else begin
            it_acc = a_q[0] ? (acc_q + b_q) : acc_q;
            it_a   = a_q >> 1;
            it_b   = b_q << 1;
        end
    end

    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix, rem_fix, fin_res;

    always_comb begin
        prod_fix = (sa_q ^ sb_q) ? -it_acc : it_acc;
        quo_fix  = (sa_q ^ sb_q) ? -it_a : it_a;
        rem_fix  = sa_q ? -it_acc[W-1:0] : it_acc[W-1:0];
        case (funct3_q[2:0])
            3'b000:          fin_res = prod_fix[W-1:0];
            3'b001, 3'b010,
            3'b011:          fin_res = prod_fix[2*W-1:W];
            3'b100, 3'b101:  fin_res = quo_fix;
            default:         fin_res = rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_e) begin
                    state_d = special_e ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (flush_E) begin
                    state_d = S_IDLE;
                end else if (cnt_q == LAST) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        funct3_d = funct3_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        res_d    = res_q;
        busy_d   = (state_d == S_RUN);
        done_d   = (state_d == S_DONE);
        case (state_q)
            S_IDLE: begin
                if (accept_e) begin
                    funct3_d = funct3_E;
                    sa_d     = sa_e;
                    sb_d     = sb_e;
                    a_d      = mag_a_e;
                    b_d      = {{W{1'b0}}, mag_b_e};
                    acc_d    = '0;
                    cnt_d    = '0;
                    if (special_e) begin
                        res_d = special_res_e;
                    end
                end
            end
            S_RUN: begin
                if (!flush_E) begin
                    cnt_d = cnt_q + CW'(1);
                    a_d   = it_a;
                    b_d   = it_b;
                    acc_d = it_acc;
                    if (cnt_q == LAST) begin
                        res_d = fin_res;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            funct3_q <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            res_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            funct3_q <= funct3_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            res_q    <= res_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign stall_E      = (state_q == S_IDLE && accept_e) || (state_q == S_RUN);
    assign busy         = busy_q;
    assign done         = done_q;
    assign mdu_result_E = res_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Bench for mdu_seq: vector table over all ops plus flush, reset and back-to-back sequences.
module tb_mdu_seq;

    logic        clk;
    logic        rst_n;
    logic        start_E;
    logic [2:0]  funct3_E;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        flush_E;
    logic        stall_E;
    logic        busy;
    logic        done;
    logic [31:0] mdu_result_E;

    mdu_seq #(.OP_WIDTH(32), .FUNCT3_WIDTH(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_E      (start_E),
        .funct3_E     (funct3_E),
        .opA          (opA),
        .opB          (opB),
        .flush_E      (flush_E),
        .stall_E      (stall_E),
        .busy         (busy),
        .done         (done),
        .mdu_result_E (mdu_result_E)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        string       name;
    } vec_t;

    vec_t        vecs[18];
    logic [31:0] exp_q[$];
    int          checks;
    int          errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic sb_pop(input string name);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: done with empty scoreboard, result 0x%08h", name, mdu_result_E);
        end else begin
            chk({name, " result"}, mdu_result_E, exp_q.pop_front());
        end
    endtask

    // Issue one op in cycle 0, release start, and wait (bounded) for done
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input string name);
        int cyc;
        bit got;
        bit stall_bad;
        @(negedge clk);
        start_E  = 1'b1;
        funct3_E = f;
        opA      = a;
        opB      = b;
        flush_E  = 1'b0;
        exp_q.push_back(exp);
        #1;
        stall_bad = (stall_E !== 1'b1);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 100) begin
            @(negedge clk);
            start_E = 1'b0;
            cyc++;
            #1;
            if (done === 1'b1) begin
                got = 1'b1;
                sb_pop(name);
                chk({name, " latency"}, cyc, lat);
                chk({name, " stall in done"}, {31'b0, stall_E}, 32'd0);
            end else if (stall_E !== 1'b1) begin
                stall_bad = 1'b1;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no done within %0d cycles, required %0d", name, cyc, lat);
            void'(exp_q.pop_front());
        end
        chk({name, " stall while pending"}, {31'b0, stall_bad}, 32'd0);
    endtask

    initial begin
        int n_done;
        int dcyc[2];
        checks = 0;
        errors = 0;

        vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, "MUL 7*-3"};
        vecs[1]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, "MULH min*min"};
        vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "MULHU max*max"};
        vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33, "MULHSU -1*2"};
        vecs[4]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33, "MULH -1*-1"};
        vecs[5]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, "DIV -7/2"};
        vecs[6]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, "REM -7/2"};
        vecs[7]  = '{3'b100, 32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, 33, "DIV 20/-3"};
        vecs[8]  = '{3'b110, 32'd20,       32'hFFFFFFFD, 32'h00000002, 33, "REM 20/-3"};
        vecs[9]  = '{3'b111, 32'hFFFFFFFF, 32'd10,       32'h00000005, 33, "REMU max/10"};
        vecs[10] = '{3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33, "DIVU min/max"};
        vecs[11] = '{3'b101, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33, "DIVU max/1"};
        vecs[12] = '{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  "DIVU 5/0"};
        vecs[13] = '{3'b110, 32'd5,        32'd0,        32'h00000005, 1,  "REM 5/0"};
        vecs[14] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  "DIV ovf"};
        vecs[15] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,  "REM ovf"};
        vecs[16] = '{3'b111, 32'd100,      32'd7,        32'h00000002, 33, "REMU 100/7"};
        vecs[17] = '{3'b101, 32'd100,      32'd7,        32'h0000000E, 33, "DIVU 100/7"};

        rst_n    = 1'b0;
        start_E  = 1'b0;
        flush_E  = 1'b0;
        funct3_E = 3'b000;
        opA      = '0;
        opB      = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset done", {31'b0, done}, 32'd0);
        chk("reset result", mdu_result_E, 32'd0);
        chk("reset stall", {31'b0, stall_E}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            do_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].name);
        end

        // Flush in cycle 10 of a MUL; last completed result is 14 from DIVU 100/7
        @(negedge clk);
        start_E  = 1'b1;
        funct3_E = 3'b000;
        opA      = 32'd5;
        opB      = 32'd6;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c == 1)  start_E = 1'b0;
            if (c == 10) flush_E = 1'b1;
            if (c == 11) flush_E = 1'b0;
            #1;
            if (c == 11) begin
                chk("flush busy", {31'b0, busy}, 32'd0);
                chk("flush done", {31'b0, done}, 32'd0);
                chk("flush stall", {31'b0, stall_E}, 32'd0);
                chk("flush result kept", mdu_result_E, 32'd14);
            end
        end
        do_op(3'b000, 32'd5, 32'd6, 32'd30, 33, "MUL after flush");

        // start together with flush in IDLE is dropped
        @(negedge clk);
        start_E  = 1'b1;
        flush_E  = 1'b1;
        funct3_E = 3'b100;
        opA      = 32'd9;
        opB      = 32'd0;
        #1;
        chk("idle flush stall", {31'b0, stall_E}, 32'd0);
        @(negedge clk);
        start_E = 1'b0;
        flush_E = 1'b0;
        #1;
        chk("idle flush busy", {31'b0, busy}, 32'd0);
        chk("idle flush done", {31'b0, done}, 32'd0);
        chk("idle flush result", mdu_result_E, 32'd30);

        // Reset in cycle 20 of a DIV
        @(negedge clk);
        start_E  = 1'b1;
        funct3_E = 3'b100;
        opA      = 32'd100;
        opB      = 32'd7;
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            if (c == 1)  start_E = 1'b0;
            if (c == 20) rst_n = 1'b0;
            #1;
            if (c == 19) chk("pre-reset busy", {31'b0, busy}, 32'd1);
            if (c == 21) begin
                chk("midop reset busy", {31'b0, busy}, 32'd0);
                chk("midop reset done", {31'b0, done}, 32'd0);
                chk("midop reset result", mdu_result_E, 32'd0);
                chk("midop reset stall", {31'b0, stall_E}, 32'd0);
                rst_n = 1'b1;
            end
        end

        // Back-to-back: MUL 3*4 held through DONE, DIV 12/5 presented the cycle after
        @(negedge clk);
        start_E  = 1'b1;
        funct3_E = 3'b000;
        opA      = 32'd3;
        opB      = 32'd4;
        exp_q.push_back(32'd12);
        n_done  = 0;
        dcyc[0] = -1;
        dcyc[1] = -1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (c == 34) begin
                funct3_E = 3'b100;
                opA      = 32'd12;
                opB      = 32'd5;
                exp_q.push_back(32'd2);
            end
            if (c == 35) start_E = 1'b0;
            #1;
            if (done === 1'b1) begin
                if (n_done < 2) dcyc[n_done] = c;
                n_done++;
                sb_pop("b2b");
            end
        end
        chk("b2b done count", n_done, 32'd2);
        chk("b2b first done cycle", dcyc[0], 32'd33);
        chk("b2b second done cycle", dcyc[1], 32'd67);
        chk("scoreboard drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
# mdu_seq

Iterative multiply/divide sequencer for the execute stage of the 5-stage RV32 pipeline, implementing the M-extension ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) alongside the single-cycle ALU. The block accepts a start request from the E stage and holds the pipeline through a stall output while it runs 32 shift-add or restoring-divide iterations. It delivers the 32-bit result with a one-cycle done pulse, during which the pipeline advances. Special divide cases (divide-by-zero, signed overflow) complete without iterating.

## Interface
- OP_WIDTH, 32, operand/result width (only 32 supported)
- FUNCT3_WIDTH, 3, funct3 width
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- start_E  in  1  E-stage instruction is an M-ext op (decoded upstream)
- funct3_E  in  FUNCT3_WIDTH  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- opA  in  OP_WIDTH  rs1 value (post-forwarding)
- opB  in  OP_WIDTH  rs2 value (post-forwarding)
- flush_E  in  1  E-stage flush (branch/jump redirect); aborts operation
- stall_E  out  1  hold IF/ID/E; combinational
- busy  out  1  registered; high in RUN
- done  out  1  registered; one-cycle pulse, result valid
- mdu_result_E  out  OP_WIDTH  registered result; held until next accepted start

## Operation
- States: IDLE, RUN, DONE. Reset (rst_n=0 at edge): state=IDLE, busy=0, done=0, mdu_result_E=0, iteration counter=0, internal accumulators=0.
- IDLE: if flush_E, stay IDLE. Else if start_E: latch funct3, signs, and magnitudes of opA/opB.
  - Signedness: MUL/MULH/DIV/REM treat both operands as signed. MULHSU treats opA as signed, opB as unsigned. MULHU/DIVU/REMU treat both as unsigned.
  - Divide special cases go straight to DONE with no iterations:
    - opB==0: quotient = 0xFFFFFFFF; remainder = opA.
    - Signed op with opA==0x80000000 and opB==0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
  - All other ops: counter=0, go to RUN.
- RUN: one iteration per cycle; counter increments; after counter==31, go to DONE.
  - Multiply: unsigned shift-add on a 64-bit accumulator, one multiplier bit per cycle (LSB first).
  - Divide: restoring division on magnitudes, one quotient bit per cycle (MSB first); remainder is 33-bit.
- DONE: done=1; mdu_result_E written on entry to DONE.
  - Sign fix-up:
    - Product negated if the operand signs differ (signed operands only).
    - Quotient negated if sA^sB.
    - Remainder negated if sA.
  - Result select: MUL → product[31:0]; MULH/MULHSU/MULHU → product[63:32]; DIV/DIVU → quotient; REM/REMU → remainder.
  - Next state is IDLE unconditionally. start_E in DONE is ignored because it belongs to the instruction completing now.
- flush_E in RUN or DONE: next state IDLE, done=0 next cycle, mdu_result_E unchanged. flush_E takes priority over start_E and over DONE entry.
- stall_E = (state==IDLE & start_E & ~flush_E) | (state==RUN). stall_E is low in DONE so the instruction leaves E with the result.
- All arithmetic is modulo 2^32 on the result; there are no exceptions.

## Timing
- Start accepted at edge ending cycle 0 (IDLE, start_E=1).
- Normal ops: RUN in cycles 1–32; DONE (done=1, result valid) in cycle 33; IDLE in cycle 34. stall_E is high in cycles 0–32.
- Special divide: DONE in cycle 1; stall_E is high in cycle 0 only.
- Back-to-back M-ext ops: the second instruction reaches E in the cycle after DONE, where state is IDLE, so it is accepted with no bubble beyond that.
- Reset mid-operation: IDLE on the next cycle; busy, done and result cleared.
- busy == (state==RUN); done == (state==DONE).

## Test plan
- MUL: opA=7, opB=0xFFFFFFFD (-3) → done in cycle 33, mdu_result_E=0xFFFFFFEB; stall_E high cycles 0–32, low in 33.
- High products:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- Signed divide: DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2; each done in cycle 33.
- Special cases:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM 0x80000000/0xFFFFFFFF → 0.
  - Each done in cycle 1; stall_E high only in cycle 0.
- Flush and reset:
  - Start MUL, assert flush_E in cycle 10 → IDLE in cycle 11, no done pulse, result unchanged, stall_E low.
  - A new start in cycle 12 completes normally in cycle 45.
  - rst_n=0 in cycle 20 of a DIV → all outputs 0 the next cycle.
- Back-to-back: MUL 3×4 then DIV 12/5 consecutively → done in cycle 33 with 12, done in cycle 67 with 2; start_E held high during DONE does not retrigger.
